// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry FIFO of {instruction, PC+4} between fetch and decode.
// The head entry is presented pre-split into MIPS R/I/J and FP fields, all zero when empty.
module if_id_queue #(
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [INST_W-1:0] Inst,
  input  logic [PC_W-1:0]   PC_4,
  input  logic              IF_Flush,
  input  logic              ID_stall,
  output logic              Out_valid,
  output logic [5:0]        Op_code,
  output logic [4:0]        Rs_ID,
  output logic [4:0]        Rt_ID,
  output logic [4:0]        Rd_ID,
  output logic [4:0]        Shamt_ID,
  output logic [5:0]        Funct_ID,
  output logic [15:0]       Imm16_ID,
  output logic [25:0]       Jmp_Adrs_ID,
  output logic [4:0]        Fmt,
  output logic [4:0]        Fs,
  output logic [4:0]        Fd,
  output logic [PC_W-1:0]   PC_ID,
  output logic [CNT_W-1:0]  Count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [PC_W-1:0]   r_pc_mem   [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;
  logic [INST_W-1:0] w_head_inst;
  logic [PC_W-1:0]   w_head_pc;

  // Handshake: an entry transfers on an edge where valid && ready (and no flush).
  // In: ready depends only on Count (no full-bypass), so it never follows ID_stall.
  // Out: valid depends only on Count (no empty-bypass); decode consumes when !ID_stall.
  assign In_ready  = (r_count < CNT_W'(DEPTH));
  assign Out_valid = (r_count != '0);
  assign Count     = r_count;

  assign w_push = In_valid && In_ready && !IF_Flush;
  assign w_pop  = Out_valid && !ID_stall && !IF_Flush;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (IF_Flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; Count alone decides which slots hold live data.
  always_ff @(posedge Clk) begin
    if (w_push && !Rst) begin
      r_inst_mem[r_wr_ptr] <= Inst;
      r_pc_mem[r_wr_ptr]   <= PC_4;
    end
  end

  assign w_head_inst = Out_valid ? r_inst_mem[r_rd_ptr] : '0;
  assign w_head_pc   = Out_valid ? r_pc_mem[r_rd_ptr]   : '0;

  assign Op_code     = w_head_inst[31:26];
  assign Rs_ID       = w_head_inst[25:21];
  assign Rt_ID       = w_head_inst[20:16];
  assign Rd_ID       = w_head_inst[15:11];
  assign Shamt_ID    = w_head_inst[10:6];
  assign Funct_ID    = w_head_inst[5:0];
  assign Imm16_ID    = w_head_inst[15:0];
  assign Jmp_Adrs_ID = w_head_inst[25:0];
  assign Fmt         = w_head_inst[25:21];
  assign Fs          = w_head_inst[15:11];
  assign Fd          = w_head_inst[10:6];
  assign PC_ID       = w_head_pc;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, field split, fill/drain, steady stream with wrap, flush, reset.
module tb_if_id_queue;

  logic        Clk;
  logic        Rst;
  logic        In_valid;
  logic        In_ready;
  logic [31:0] Inst;
  logic [31:0] PC_4;
  logic        IF_Flush;
  logic        ID_stall;
  logic        Out_valid;
  logic [5:0]  Op_code;
  logic [4:0]  Rs_ID;
  logic [4:0]  Rt_ID;
  logic [4:0]  Rd_ID;
  logic [4:0]  Shamt_ID;
  logic [5:0]  Funct_ID;
  logic [15:0] Imm16_ID;
  logic [25:0] Jmp_Adrs_ID;
  logic [4:0]  Fmt;
  logic [4:0]  Fs;
  logic [4:0]  Fd;
  logic [31:0] PC_ID;
  logic [2:0]  Count;

  int          n_checks;
  int          n_bad;
  logic [31:0] exp_q[$];
  logic [31:0] next_pc;

  if_id_queue #(.INST_W(32), .PC_W(32), .DEPTH(4)) dut (
    .Clk(Clk), .Rst(Rst), .In_valid(In_valid), .In_ready(In_ready),
    .Inst(Inst), .PC_4(PC_4), .IF_Flush(IF_Flush), .ID_stall(ID_stall),
    .Out_valid(Out_valid), .Op_code(Op_code), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .Rd_ID(Rd_ID), .Shamt_ID(Shamt_ID), .Funct_ID(Funct_ID), .Imm16_ID(Imm16_ID),
    .Jmp_Adrs_ID(Jmp_Adrs_ID), .Fmt(Fmt), .Fs(Fs), .Fd(Fd), .PC_ID(PC_ID),
    .Count(Count)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_count"}, 128'(Count), 128'(0));
    check({tag, "_out_valid"}, 128'(Out_valid), 128'(0));
    check({tag, "_in_ready"}, 128'(In_ready), 128'(1));
    check({tag, "_fields"},
          128'({Op_code, Rs_ID, Rt_ID, Rd_ID, Shamt_ID, Funct_ID, Imm16_ID,
                Jmp_Adrs_ID, Fmt, Fs, Fd}), 128'(0));
    check({tag, "_pc_id"}, 128'(PC_ID), 128'(0));
  endtask

  // driver: one accepted-or-not push attempt on the next edge
  task automatic push_entry(input logic [31:0] inst, input logic [31:0] pc);
    In_valid = 1'b1;
    Inst     = inst;
    PC_4     = pc;
    tick();
    In_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_bad    = 0;
    Rst      = 1'b1;
    In_valid = 1'b0;
    Inst     = '0;
    PC_4     = '0;
    IF_Flush = 1'b0;
    ID_stall = 1'b0;

    // 1: reset state
    tick();
    tick();
    Rst = 1'b0;
    check_empty("reset");

    // 2: single entry field split, 1-cycle latency, popped next edge
    push_entry(32'hFC1F07C0, 32'h4);
    check("t2_valid", 128'(Out_valid), 128'(1));
    check("t2_op", 128'(Op_code), 128'(6'b111111));
    check("t2_rs", 128'(Rs_ID), 128'(5'b00000));
    check("t2_rt", 128'(Rt_ID), 128'(5'b11111));
    check("t2_rd", 128'(Rd_ID), 128'(5'b00000));
    check("t2_shamt", 128'(Shamt_ID), 128'(5'b11111));
    check("t2_funct", 128'(Funct_ID), 128'(6'b000000));
    check("t2_imm", 128'(Imm16_ID), 128'(16'h07C0));
    check("t2_jmp", 128'(Jmp_Adrs_ID), 128'(26'h01F07C0));
    check("t2_fp", 128'({Fmt, Fs, Fd}), 128'({5'h00, 5'h00, 5'h1F}));
    check("t2_pc", 128'(PC_ID), 128'(32'h4));
    check("t2_count", 128'(Count), 128'(1));
    tick();
    check("t2_drained", 128'(Out_valid), 128'(0));

    // 3: fill under stall, 5th push refused, then drain in order
    ID_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_ready%0d", i), 128'(In_ready), 128'(i < 4));
      push_entry(32'h1000_0000 + 32'(i), 32'(4 * (i + 1)));
    end
    check("t3_count_full", 128'(Count), 128'(4));
    check("t3_ready_full", 128'(In_ready), 128'(0));
    check("t3_head_stalled", 128'(PC_ID), 128'(32'h4));
    check("t3_head_inst", 128'(Imm16_ID), 128'(16'h0000));
    ID_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_drain_pc%0d", k), 128'(PC_ID), 128'(4 * (k + 1)));
      tick();
    end
    check("t3_empty_after", 128'(Out_valid), 128'(0));

    // 4: full with pop and push requested; then steady push+pop across wrap
    ID_stall = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      push_entry(32'(4 * (i + 1)), 32'(4 * (i + 1)));
      exp_q.push_back(32'(4 * (i + 1)));
    end
    next_pc  = 32'd20;
    ID_stall = 1'b0;
    In_valid = 1'b1;
    Inst     = next_pc;
    PC_4     = next_pc;
    check("t4_ready_full_pop", 128'(In_ready), 128'(0));
    check("t4_count4", 128'(Count), 128'(4));
    tick();
    void'(exp_q.pop_front());
    for (int c = 0; c < 10; c++) begin
      check($sformatf("t4_count%0d", c), 128'(Count), 128'(3));
      check($sformatf("t4_ready%0d", c), 128'(In_ready), 128'(1));
      check($sformatf("t4_pc%0d", c), 128'(PC_ID), 128'(exp_q[0]));
      Inst = next_pc;
      PC_4 = next_pc;
      tick();
      exp_q.push_back(next_pc);
      void'(exp_q.pop_front());
      next_pc = next_pc + 32'd4;
    end
    In_valid = 1'b0;

    // 5: flush with a simultaneous push
    ID_stall = 1'b1;
    tick();
    check("t5_count3", 128'(Count), 128'(3));
    IF_Flush = 1'b1;
    In_valid = 1'b1;
    Inst     = 32'hDEADBEEF;
    PC_4     = 32'h0000BAD0;
    tick();
    IF_Flush = 1'b0;
    In_valid = 1'b0;
    check_empty("t5_flush");
    ID_stall = 1'b0;
    tick();
    check("t5_no_ghost", 128'(Out_valid), 128'(0));
    exp_q.delete();

    // 6: reset mid-stream while stalled
    ID_stall = 1'b1;
    push_entry(32'h2000_0040, 32'h40);
    push_entry(32'h2000_0044, 32'h44);
    check("t6_count2", 128'(Count), 128'(2));
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("t6_count0", 128'(Count), 128'(0));
    check("t6_ready", 128'(In_ready), 128'(1));
    ID_stall = 1'b0;
    push_entry(32'h2400_0100, 32'h100);
    check("t6_valid", 128'(Out_valid), 128'(1));
    check("t6_pc", 128'(PC_ID), 128'(32'h100));
    check("t6_imm", 128'(Imm16_ID), 128'(16'h0100));
    tick();
    check("t6_drained", 128'(Out_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
